wrp_shff_rd_ctrl: RTL and testbench

//  Read-side sequencer for the shuffle buffer: drains 1024-block frames in transposed (col-major) order
//  and streams them to the AIE over AXI4-Stream. Waits on buf_empty, issues buffer reads and re-times

---
 rtl/wrp_shff_rd_ctrl.sv | 92 +++++++++
 tb/tb_wrp_shff_rd_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wrp_shff_rd_ctrl.sv
// wrp_shff_rd_ctrl: drains shuffle-buffer frames in transposed order to an AXI4-Stream via a credit-guarded skid FIFO
module wrp_shff_rd_ctrl #(
  parameter int DW = 128,
  parameter int BLK_BEATS = 8,
  parameter int NROW = 32,
  parameter int NCOL = 32,
  parameter int RD_LAT = 2,
  parameter int OFIFO_D = 4,
  localparam int AW = $clog2(NROW * NCOL * BLK_BEATS)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          buf_empty,
  output logic          buf_rdone,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready
);
  localparam int BW = $clog2(BLK_BEATS);
  localparam int RB = $clog2(NROW);
  localparam int CB = $clog2(NCOL);
  localparam int PW = $clog2(OFIFO_D);
  localparam int CW = $clog2(OFIFO_D + RD_LAT + 2) + 1;
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
  state_t state, state_nx;
  logic hold;
  logic [BW-1:0] beat;
  logic [RB+CB-1:0] rd_cnt;
  logic [RD_LAT-1:0] vld, lst;
  logic [DW-1:0] mem [OFIFO_D];
  logic [OFIFO_D-1:0] mem_last;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic issue, last_beat, push, pop;
  logic [CW-1:0] occ;
  assign push = vld[RD_LAT-1];
  assign pop = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = cnt != '0;
  assign m_axis_tdata = m_axis_tvalid ? mem[rp] : '0;
  assign m_axis_tlast = m_axis_tvalid && mem_last[rp];
  // occupancy counts every beat already destined for the FIFO, net of this cycle's pop
  always_comb begin
    occ = CW'(cnt) + CW'(rd_en) - CW'(pop);
    for (int i = 0; i < RD_LAT; i++) occ = occ + CW'(vld[i]);
    last_beat = beat == BW'(BLK_BEATS - 1);
    issue = state == READ && occ < CW'(OFIFO_D);
    state_nx = state == IDLE ? (buf_empty ? IDLE : READ)
             : state == READ ? (issue && last_beat ? HOLD : READ)
             : (hold ? IDLE : HOLD);
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
      hold <= 1'b0;
      beat <= '0;
      rd_cnt <= '0;
      rd_en <= 1'b0;
      rd_addr <= '0;
      buf_rdone <= 1'b0;
      vld <= '0;
      lst <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      hold <= state == HOLD && !hold;
      rd_en <= issue;
      buf_rdone <= issue && last_beat;
      vld <= RD_LAT'({vld, rd_en});
      lst <= RD_LAT'({lst, buf_rdone});
      if (issue) begin
        rd_addr <= {rd_cnt[RB-1:0], rd_cnt[RB+CB-1:RB], beat};
        beat <= beat + BW'(1);
        if (last_beat) rd_cnt <= rd_cnt + (RB+CB)'(1);
      end
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= rd_data;
      mem_last[wp] <= lst[RD_LAT-1];
    end
  end
endmodule

// File: tb/tb_wrp_shff_rd_ctrl.sv
// tb_wrp_shff_rd_ctrl: scoreboard bench with a latency-2 buffer model and directed scenarios
module tb_wrp_shff_rd_ctrl;
  localparam int DW = 128;
  localparam int BB = 8;
  localparam int AW = 13;
  localparam int OD = 4;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 1'b0;
  logic srst = 1'b1;
  logic buf_empty = 1'b1;
  logic m_axis_tready = 1'b1;
  logic buf_rdone, rd_en, m_axis_tvalid, m_axis_tlast;
  logic [AW-1:0] rd_addr, p0, p1;
  logic [DW-1:0] rd_data, m_axis_tdata;
  logic [AW-1:0] q_addr[$];
  beat_t q_out[$];
  int checks = 0, failures = 0, nb = 0, cyc = 0;
  int rdone_cnt = 0, rd_issued = 0, pop_cnt = 0, tlast_cnt = 0;
  int first_rd_cyc = -1, last_rdone_cyc = -1;
  logic prev_stall = 1'b0, prev_l;
  logic [DW-1:0] prev_d;
  always #5 clk = ~clk;
  wrp_shff_rd_ctrl dut (
    .clk(clk), .srst(srst), .buf_empty(buf_empty), .buf_rdone(buf_rdone),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );
  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return {19'h5A5A5 ^ 19'(a), 32'(a) * 32'h9E3779B1, 32'hCAFE0000 | 32'(a), 32'(~a), a};
  endfunction
  function automatic logic [AW-1:0] eaddr(input int b, input int bt);
    logic [9:0] r;
    logic [2:0] t;
    r = 10'(b);
    t = 3'(bt);
    return {r[4:0], r[9:5], t};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p0 <= rd_addr;
    p1 <= p0;
  end
  assign rd_data = fdat(p1);
  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask
  task automatic plan(input int n);
    for (int k = 0; k < n; k++) begin
      for (int bt = 0; bt < BB; bt++) begin
        q_addr.push_back(eaddr(nb, bt));
        q_out.push_back('{fdat(eaddr(nb, bt)), bt == BB - 1});
      end
      nb++;
    end
  endtask
  always @(negedge clk) begin
    if (srst) begin
      prev_stall = 1'b0;
      rd_issued = pop_cnt;
    end else begin
      if (rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_issued++;
        if (q_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_en_unexpected actual=%0h expected=none", rd_addr);
        end else begin
          logic [AW-1:0] ea;
          ea = q_addr.pop_front();
          chk("rd_addr", rd_addr, ea);
          chk("rdone_on_last", buf_rdone, ea[2:0] == 3'(BB - 1));
        end
      end else chk("rdone_without_rd", buf_rdone, 0);
      if (buf_rdone) begin
        if (last_rdone_cyc >= 0) chk("rdone_gap_ok", cyc - last_rdone_cyc >= BB + 3, 1);
        last_rdone_cyc = cyc;
        rdone_cnt++;
      end
      if (prev_stall) begin
        chk("tvalid_held", m_axis_tvalid, 1);
        chk("tdata_stable", m_axis_tdata, prev_d);
        chk("tlast_stable", m_axis_tlast, prev_l);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        pop_cnt++;
        if (m_axis_tlast) tlast_cnt++;
        if (q_out.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=%0h expected=none", m_axis_tdata);
        end else begin
          beat_t e;
          e = q_out.pop_front();
          chk("tdata", m_axis_tdata, e.d);
          chk("tlast", m_axis_tlast, e.l);
        end
      end
      chk("outstanding_le_depth", rd_issued - pop_cnt <= OD, 1);
    end
  end
  task automatic wait_rdones(input int target);
    int t = 0;
    while (rdone_cnt < target && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rdone_wait", rdone_cnt >= target, 1);
    buf_empty = 1'b1;
  endtask
  task automatic drain();
    int t = 0;
    int s;
    while ((q_out.size() != 0 || q_addr.size() != 0) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_done", q_out.size() == 0 && q_addr.size() == 0, 1);
    s = rd_issued;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_rd", rd_issued - s, 0);
    chk("idle_no_tvalid", m_axis_tvalid, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d, s, p, l, rb, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rdone", buf_rdone, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    @(posedge clk);
    #1 srst = 1'b0;
    s = rd_issued;
    repeat (30) @(posedge clk);
    #1;
    chk("t4_no_rd", rd_issued - s, 0);
    chk("t4_no_rdone", rdone_cnt, 0);
    chk("t4_no_tvalid", pop_cnt, 0);
    plan(1);
    first_rd_cyc = -1;
    d = cyc;
    buf_empty = 1'b0;
    wait_rdones(1);
    chk("t4_first_rd_latency", first_rd_cyc - d, 2);
    drain();
    plan(1024);
    p = pop_cnt;
    l = tlast_cnt;
    d = cyc;
    buf_empty = 1'b0;
    wait_rdones(1025);
    chk("t2_rate", last_rdone_cyc - d, 9 + (BB + 3) * 1023);
    drain();
    chk("t2_beats", pop_cnt - p, 8192);
    chk("t2_tlast", tlast_cnt - l, 1024);
    plan(2);
    rb = rdone_cnt;
    p = pop_cnt;
    buf_empty = 1'b0;
    t = 0;
    while (pop_cnt < p + 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("t3_started", pop_cnt >= p + 3, 1);
    m_axis_tready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t3_outstanding_full", rd_issued - pop_cnt, OD);
    chk("t3_no_rdone_in_stall", rdone_cnt, rb);
    m_axis_tready = 1'b1;
    wait_rdones(rb + 2);
    drain();
    plan(1);
    rb = rdone_cnt;
    buf_empty = 1'b0;
    t = 0;
    while (!(rd_en && rd_addr[2:0] == 3'd4) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("t6_reached_beat4", rd_en && rd_addr[2:0] == 3'd4, 1);
    srst = 1'b1;
    @(posedge clk);
    #1;
    q_addr.delete();
    q_out.delete();
    nb = 0;
    @(negedge clk);
    chk("t6_rd_en", rd_en, 0);
    chk("t6_rd_addr", rd_addr, 0);
    chk("t6_rdone", buf_rdone, 0);
    chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_tdata", m_axis_tdata, 0);
    chk("t6_no_rdone_cnt", rdone_cnt, rb);
    plan(1);
    @(posedge clk);
    #1 srst = 1'b0;
    first_rd_cyc = -1;
    d = cyc;
    wait_rdones(rb + 1);
    chk("t6_restart_latency", first_rd_cyc - d, 2);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
